// File: rtl/pwr_pkg.sv
// Shared definitions for the power-request initiator: power-state codes,
// handshake FSM encoding and wake-kick cadence.
package pwr_pkg;

    localparam logic [1:0] PWR_ACTIVE = 2'b00;
    localparam logic [1:0] PWR_IDLE   = 2'b01;
    localparam logic [1:0] PWR_SLEEP  = 2'b10;
    localparam logic [1:0] PWR_OFF    = 2'b11;

    typedef enum logic [1:0] {
        ST_STABLE = 2'd0,
        ST_QUIET  = 2'd1,
        ST_REQ    = 2'd2
    } pwr_fsm_e;

    localparam int KICK_LOG2   = 3;
    localparam int KICK_PERIOD = 1 << KICK_LOG2;

    // Waking up is always allowed; otherwise only a deeper state may be requested.
    function automatic logic req_is_legal(input logic [1:0] target, input logic [1:0] cur);
        return (target == PWR_ACTIVE) || (target > cur);
    endfunction

endpackage

// File: rtl/pwr_quiet_timer.sv
// Loadable saturating up-counter shared by the bus-quiet wait and the ack timeout.
module pwr_quiet_timer #(
    parameter int CNT_W = 16
) (
    input  logic             i_sys_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    assign at_max = &count_q;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = i_load_val;
        end else if (i_inc && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    // Terminal count flags the increment that makes the count equal the limit.
    assign o_tc    = i_inc && ((count_q + 1'b1) == i_limit);

endmodule

// File: rtl/pwr_req_ctrl.sv
// Initiator side of the power-state handshake: legality check, bus-quiet wait,
// request/ack with timeout, wake handling and status pulses.
module pwr_req_ctrl
    import pwr_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 2048,
    parameter int QUIET_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic       i_sys_clk,
    input  logic       i_rst,
    input  logic       i_sw_req_valid,
    input  logic [1:0] i_sw_req_state,
    input  logic       i_xfer_busy,
    input  logic [1:0] i_power_state_ack,
    input  logic       i_wake_up_event,
    input  logic       i_err_clr,
    output logic [1:0] o_power_state_req,
    output logic       o_wake_up_en,
    output logic       o_wake_kick,
    output logic [1:0] o_cur_state,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_req_reject,
    output logic       o_timeout_err,
    output logic       o_wake_irq
);

    pwr_fsm_e   state_q, state_d;
    logic [1:0] target_q, target_d;
    logic [1:0] req_q, req_d;
    logic [1:0] cur_q, cur_d;
    logic [1:0] ack_q;
    logic       wake_en_q, wake_en_d;
    logic       kick_mode_q, kick_mode_d;
    logic       kick_q, kick_d;
    logic       done_q, done_d;
    logic       reject_q, reject_d;
    logic       terr_q, terr_d;
    logic       wake_irq_q, wake_irq_d;
    logic       terr_set;
    logic       active_req;

    logic             tmr_clr;
    logic             tmr_inc;
    logic [CNT_W-1:0] tmr_limit;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_tc;

    // Counter idles at zero in ST_STABLE so each handshake phase starts from a clean count.
    assign tmr_inc   = ((state_q == ST_QUIET) && !i_xfer_busy) || (state_q == ST_REQ);
    assign tmr_clr   = (state_q == ST_STABLE) ||
                       ((state_q == ST_QUIET) && (i_xfer_busy || tmr_tc));
    assign tmr_limit = (state_q == ST_QUIET) ? CNT_W'(QUIET_CYCLES) : CNT_W'(ACK_TIMEOUT);

    pwr_quiet_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_sys_clk  (i_sys_clk),
        .i_rst      (i_rst),
        .i_clr      (tmr_clr),
        .i_load     (1'b0),
        .i_load_val ({CNT_W{1'b0}}),
        .i_inc      (tmr_inc),
        .i_limit    (tmr_limit),
        .o_count    (tmr_count),
        .o_tc       (tmr_tc)
    );

    assign active_req = (state_q == ST_REQ) && (target_q == PWR_ACTIVE);

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        req_d       = req_q;
        cur_d       = cur_q;
        wake_en_d   = wake_en_q;
        kick_mode_d = kick_mode_q;
        kick_d      = 1'b0;
        done_d      = 1'b0;
        reject_d    = 1'b0;
        wake_irq_d  = 1'b0;
        terr_set    = 1'b0;

        if (i_wake_up_event && !active_req) begin
            // The power manager woke us on its own: drop anything low-power in flight.
            req_d      = PWR_ACTIVE;
            cur_d      = PWR_ACTIVE;
            wake_en_d  = 1'b0;
            wake_irq_d = 1'b1;
            reject_d   = i_sw_req_valid;
            state_d    = ST_STABLE;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (i_sw_req_valid) begin
                        if (i_sw_req_state == cur_q) begin
                            done_d = 1'b1;
                        end else if (!req_is_legal(i_sw_req_state, cur_q)) begin
                            reject_d = 1'b1;
                        end else if (i_sw_req_state == PWR_ACTIVE) begin
                            state_d     = ST_REQ;
                            target_d    = PWR_ACTIVE;
                            req_d       = PWR_ACTIVE;
                            wake_en_d   = (cur_q == PWR_OFF);
                            kick_mode_d = (cur_q == PWR_IDLE) || (cur_q == PWR_SLEEP);
                            kick_d      = kick_mode_d;
                        end else begin
                            state_d  = ST_QUIET;
                            target_d = i_sw_req_state;
                        end
                    end else if (i_power_state_ack != ack_q) begin
                        cur_d = i_power_state_ack;
                    end
                end
                ST_QUIET: begin
                    reject_d = i_sw_req_valid;
                    if (tmr_tc) begin
                        state_d     = ST_REQ;
                        req_d       = target_q;
                        kick_mode_d = 1'b0;
                        wake_en_d   = 1'b0;
                    end
                end
                ST_REQ: begin
                    reject_d = i_sw_req_valid;
                    if (i_power_state_ack == target_q) begin
                        cur_d     = target_q;
                        done_d    = 1'b1;
                        wake_en_d = 1'b0;
                        state_d   = ST_STABLE;
                    end else if (tmr_tc) begin
                        terr_set  = 1'b1;
                        req_d     = cur_q;
                        wake_en_d = 1'b0;
                        state_d   = ST_STABLE;
                    end else begin
                        kick_d = kick_mode_q &&
                                 ((tmr_count % CNT_W'(KICK_PERIOD)) == CNT_W'(KICK_PERIOD - 1));
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                end
            endcase
        end

        if (terr_set) begin
            terr_d = 1'b1;
        end else if (i_err_clr) begin
            terr_d = 1'b0;
        end else begin
            terr_d = terr_q;
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q     <= ST_STABLE;
            target_q    <= PWR_ACTIVE;
            req_q       <= PWR_ACTIVE;
            cur_q       <= PWR_ACTIVE;
            ack_q       <= PWR_ACTIVE;
            wake_en_q   <= 1'b0;
            kick_mode_q <= 1'b0;
            kick_q      <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
            terr_q      <= 1'b0;
            wake_irq_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            req_q       <= req_d;
            cur_q       <= cur_d;
            ack_q       <= i_power_state_ack;
            wake_en_q   <= wake_en_d;
            kick_mode_q <= kick_mode_d;
            kick_q      <= kick_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
            terr_q      <= terr_d;
            wake_irq_q  <= wake_irq_d;
        end
    end

    assign o_power_state_req = req_q;
    assign o_wake_up_en      = wake_en_q;
    assign o_wake_kick       = kick_q;
    assign o_cur_state       = cur_q;
    assign o_busy            = (state_q != ST_STABLE);
    assign o_done            = done_q;
    assign o_req_reject      = reject_q;
    assign o_timeout_err     = terr_q;
    assign o_wake_irq        = wake_irq_q;

endmodule

// File: tb/tb_pwr_req_ctrl.sv
// Bench for pwr_req_ctrl: constant vector table, directed handshake sequences,
// then random traffic checked against a phase/countdown reference model.
module tb_pwr_req_ctrl;

    localparam int TIMEOUT = 32;
    localparam int QUIET   = 16;
    localparam int PH_STABLE = 0;
    localparam int PH_QUIET  = 1;
    localparam int PH_REQ    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_v = 1'b0;
    logic [1:0] sw_s = 2'b00;
    logic       busy = 1'b0;
    logic [1:0] ack = 2'b00;
    logic       wake = 1'b0;
    logic       clr = 1'b0;

    logic [1:0] o_power_state_req;
    logic       o_wake_up_en;
    logic       o_wake_kick;
    logic [1:0] o_cur_state;
    logic       o_busy;
    logic       o_done;
    logic       o_req_reject;
    logic       o_timeout_err;
    logic       o_wake_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwr_req_ctrl #(
        .ACK_TIMEOUT  (TIMEOUT),
        .QUIET_CYCLES (QUIET),
        .CNT_W        (16)
    ) dut (
        .i_sys_clk         (clk),
        .i_rst             (rst),
        .i_sw_req_valid    (sw_v),
        .i_sw_req_state    (sw_s),
        .i_xfer_busy       (busy),
        .i_power_state_ack (ack),
        .i_wake_up_event   (wake),
        .i_err_clr         (clr),
        .o_power_state_req (o_power_state_req),
        .o_wake_up_en      (o_wake_up_en),
        .o_wake_kick       (o_wake_kick),
        .o_cur_state       (o_cur_state),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_req_reject      (o_req_reject),
        .o_timeout_err     (o_timeout_err),
        .o_wake_irq        (o_wake_irq)
    );

    // Reference model: handshake phase plus countdown/age bookkeeping.
    int m_phase, m_target, m_req, m_cur, m_prev_ack, m_quiet_left, m_age;
    bit m_wake_en, m_kick, m_done, m_rej, m_terr, m_wirq, m_kick_mode;

    task automatic model_step();
        bit timed_out;
        int s;
        int a;
        s = int'(sw_s);
        a = int'(ack);
        timed_out = 0;
        m_kick = 0; m_done = 0; m_rej = 0; m_wirq = 0;
        if (rst) begin
            m_phase = PH_STABLE; m_target = 0; m_req = 0; m_cur = 0; m_prev_ack = 0;
            m_quiet_left = 0; m_age = 0; m_wake_en = 0; m_terr = 0; m_kick_mode = 0;
            return;
        end
        if (wake && !(m_phase == PH_REQ && m_target == 0)) begin
            m_req = 0; m_cur = 0; m_wirq = 1; m_wake_en = 0; m_phase = PH_STABLE;
            m_rej = sw_v;
        end else if (m_phase == PH_STABLE) begin
            if (sw_v) begin
                if (s == m_cur) begin
                    m_done = 1;
                end else if (s == 0) begin
                    m_phase = PH_REQ; m_target = 0; m_req = 0; m_age = 0;
                    m_wake_en = (m_cur == 3);
                    m_kick_mode = (m_cur == 1 || m_cur == 2);
                    m_kick = m_kick_mode;
                end else if (s > m_cur) begin
                    m_phase = PH_QUIET; m_target = s; m_quiet_left = QUIET;
                end else begin
                    m_rej = 1;
                end
            end else if (a != m_prev_ack) begin
                m_cur = a;
            end
        end else begin
            m_rej = sw_v;
            if (m_phase == PH_QUIET) begin
                if (busy) begin
                    m_quiet_left = QUIET;
                end else begin
                    m_quiet_left--;
                    if (m_quiet_left == 0) begin
                        m_phase = PH_REQ; m_req = m_target; m_age = 0;
                        m_kick_mode = 0; m_wake_en = 0;
                    end
                end
            end else begin
                if (a == m_target) begin
                    m_cur = m_target; m_done = 1; m_wake_en = 0; m_phase = PH_STABLE;
                end else if (m_age + 1 == TIMEOUT) begin
                    timed_out = 1; m_req = m_cur; m_wake_en = 0; m_phase = PH_STABLE;
                end else begin
                    m_age++;
                    m_kick = m_kick_mode && (m_age % 8 == 0);
                end
            end
        end
        if (timed_out) m_terr = 1;
        else if (clr) m_terr = 0;
        m_prev_ack = a;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1; sw_v = 0; sw_s = 0; busy = 0; ack = 0; wake = 0; clr = 0;
        tick();
        rst = 0;
    endtask

    task automatic wait_req(input logic [1:0] val, input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (o_power_state_req == val) begin
                n = i;
                break;
            end
        end
    endtask

    typedef struct {
        int rst, v, st, busy, ack, wake, clr;
        int e_req, e_cur, e_we, e_kick, e_busy, e_done, e_rej, e_terr, e_wirq;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int n;

        //            rst v st bsy ack wk clr | req cur we kick busy done rej terr wirq
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 1, 1, 0, 1, 0, 0,   0, 1, 0, 0, 0, 1, 0, 0, 0};
        vecs[5]  = '{0, 1, 0, 0, 1, 0, 0,   0, 1, 0, 1, 1, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 2, 0, 1, 0, 0,   0, 1, 0, 0, 1, 0, 1, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 3, 0, 0,   0, 3, 0, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 2, 0, 3, 0, 0,   0, 3, 0, 0, 0, 0, 1, 0, 0};
        vecs[13] = '{0, 1, 0, 0, 3, 0, 0,   0, 3, 1, 0, 1, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 0, 3, 1, 0,   0, 3, 1, 0, 1, 0, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[16] = '{1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 17; i++) begin
            rst  = vecs[i].rst[0];
            sw_v = vecs[i].v[0];
            sw_s = vecs[i].st[1:0];
            busy = vecs[i].busy[0];
            ack  = vecs[i].ack[1:0];
            wake = vecs[i].wake[0];
            clr  = vecs[i].clr[0];
            tick();
            $display("vec %0d: req=%0d cur=%0d we=%0d kick=%0d busy=%0d done=%0d rej=%0d terr=%0d wirq=%0d",
                     i, o_power_state_req, o_cur_state, o_wake_up_en, o_wake_kick, o_busy,
                     o_done, o_req_reject, o_timeout_err, o_wake_irq);
            chk($sformatf("vec%0d.req", i),  int'(o_power_state_req), vecs[i].e_req);
            chk($sformatf("vec%0d.cur", i),  int'(o_cur_state),       vecs[i].e_cur);
            chk($sformatf("vec%0d.we", i),   int'(o_wake_up_en),      vecs[i].e_we);
            chk($sformatf("vec%0d.kick", i), int'(o_wake_kick),       vecs[i].e_kick);
            chk($sformatf("vec%0d.busy", i), int'(o_busy),            vecs[i].e_busy);
            chk($sformatf("vec%0d.done", i), int'(o_done),            vecs[i].e_done);
            chk($sformatf("vec%0d.rej", i),  int'(o_req_reject),      vecs[i].e_rej);
            chk($sformatf("vec%0d.terr", i), int'(o_timeout_err),     vecs[i].e_terr);
            chk($sformatf("vec%0d.wirq", i), int'(o_wake_irq),        vecs[i].e_wirq);
        end
        rst = 0; clr = 0;

        // A: ACTIVE->SLEEP with idle bus, ack five cycles after the request.
        do_reset();
        sw_v = 1; sw_s = 2; tick(); sw_v = 0;
        wait_req(2'b10, 40, n);
        chk("A.quiet_len", n, QUIET);
        repeat (4) begin tick(); chk("A.early_done", int'(o_done), 0); end
        ack = 2; tick();
        chk("A.done", int'(o_done), 1);
        chk("A.cur", int'(o_cur_state), 2);
        chk("A.busy", int'(o_busy), 0);
        tick();
        chk("A.done_width", int'(o_done), 0);
        $display("seq A: sleep entry, quiet length %0d", n);

        // B: busy burst at quiet count 10 restarts the quiet window.
        do_reset();
        sw_v = 1; sw_s = 2; tick(); sw_v = 0;
        repeat (10) tick();
        busy = 1;
        repeat (3) begin tick(); chk("B.held", int'(o_power_state_req), 0); end
        busy = 0;
        wait_req(2'b10, 40, n);
        chk("B.restart_len", n, QUIET);
        $display("seq B: quiet restart, length after busy %0d", n);

        // C: wake from OFF holds wake enable until ack=ACTIVE.
        do_reset();
        ack = 3; tick();
        chk("C.cur_off", int'(o_cur_state), 3);
        sw_v = 1; sw_s = 0; tick(); sw_v = 0;
        chk("C.we_entry", int'(o_wake_up_en), 1);
        repeat (6) begin tick(); chk("C.we_hold", int'(o_wake_up_en), 1); end
        ack = 0; tick();
        chk("C.done", int'(o_done), 1);
        chk("C.we_drop", int'(o_wake_up_en), 0);
        chk("C.cur", int'(o_cur_state), 0);
        $display("seq C: exit OFF");

        // D: IDLE requested while in SLEEP is rejected.
        do_reset();
        ack = 2; tick();
        chk("D.cur_sleep", int'(o_cur_state), 2);
        sw_v = 1; sw_s = 1; tick(); sw_v = 0;
        chk("D.rej", int'(o_req_reject), 1);
        chk("D.req", int'(o_power_state_req), 0);
        chk("D.busy", int'(o_busy), 0);
        tick();
        chk("D.rej_width", int'(o_req_reject), 0);
        $display("seq D: illegal request rejected");

        // E: ack never matches; timeout, revert, clear, then set-over-clear.
        do_reset();
        sw_v = 1; sw_s = 1; tick(); sw_v = 0;
        wait_req(2'b01, 40, n);
        chk("E.quiet_len", n, QUIET);
        n = -1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (o_timeout_err) begin n = i; break; end
        end
        chk("E.timeout_len", n, TIMEOUT);
        chk("E.revert", int'(o_power_state_req), 0);
        chk("E.busy", int'(o_busy), 0);
        chk("E.no_done", int'(o_done), 0);
        tick();
        chk("E.sticky", int'(o_timeout_err), 1);
        clr = 1; tick(); clr = 0;
        chk("E.cleared", int'(o_timeout_err), 0);
        sw_v = 1; sw_s = 1; tick(); sw_v = 0;
        clr = 1;
        n = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (!o_busy) begin n = i; break; end
        end
        chk("E.set_wins_len", n, QUIET + TIMEOUT);
        chk("E.set_wins", int'(o_timeout_err), 1);
        tick(); clr = 0;
        chk("E.clr_after", int'(o_timeout_err), 0);
        $display("seq E: ack timeout after %0d cycles", TIMEOUT);

        // F: unsolicited wake during the quiet wait aborts the request.
        do_reset();
        sw_v = 1; sw_s = 2; tick(); sw_v = 0;
        repeat (5) tick();
        chk("F.in_quiet", int'(o_busy), 1);
        wake = 1; tick(); wake = 0;
        chk("F.wirq", int'(o_wake_irq), 1);
        chk("F.busy", int'(o_busy), 0);
        chk("F.no_done", int'(o_done), 0);
        chk("F.cur", int'(o_cur_state), 0);
        chk("F.req", int'(o_power_state_req), 0);
        tick();
        chk("F.wirq_width", int'(o_wake_irq), 0);
        chk("F.no_done2", int'(o_done), 0);
        $display("seq F: wake aborts quiet wait");

        // G: wake kick cadence from SLEEP.
        do_reset();
        ack = 2; tick();
        sw_v = 1; sw_s = 0; tick(); sw_v = 0;
        chk("G.kick0", int'(o_wake_kick), 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk($sformatf("G.kick%0d", k), int'(o_wake_kick), (k % 8 == 0) ? 1 : 0);
        end
        ack = 0; tick();
        chk("G.done", int'(o_done), 1);
        chk("G.kick_end", int'(o_wake_kick), 0);
        $display("seq G: wake kick every 8 cycles");

        // H: reset in the middle of a handshake.
        do_reset();
        sw_v = 1; sw_s = 3; tick(); sw_v = 0;
        repeat (20) tick();
        chk("H.req_off", int'(o_power_state_req), 3);
        rst = 1; tick(); rst = 0;
        chk("H.done", int'(o_done), 0);
        chk("H.rej", int'(o_req_reject), 0);
        chk("H.busy", int'(o_busy), 0);
        chk("H.req", int'(o_power_state_req), 0);
        tick();
        chk("H.done2", int'(o_done), 0);
        $display("seq H: reset mid-handshake");

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            sw_v = ($urandom_range(0, 11) == 0);
            sw_s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) busy = ~busy;
            wake = ($urandom_range(0, 199) == 0);
            clr  = ($urandom_range(0, 49) == 0);
            rst  = ($urandom_range(0, 999) == 0);
            r = $urandom_range(0, 39);
            if (r < 10) ack = 2'(m_req);
            else if (r == 10) ack = 2'($urandom_range(0, 3));
            if (sw_v) $display("rand cycle %0d: sw request state=%0d (model cur=%0d phase=%0d)",
                               c, sw_s, m_cur, m_phase);
            tick();
            chk("rand.req",  int'(o_power_state_req), m_req);
            chk("rand.cur",  int'(o_cur_state),       m_cur);
            chk("rand.we",   int'(o_wake_up_en),      int'(m_wake_en));
            chk("rand.kick", int'(o_wake_kick),       int'(m_kick));
            chk("rand.busy", int'(o_busy),            (m_phase != PH_STABLE) ? 1 : 0);
            chk("rand.done", int'(o_done),            int'(m_done));
            chk("rand.rej",  int'(o_req_reject),      int'(m_rej));
            chk("rand.terr", int'(o_timeout_err),     int'(m_terr));
            chk("rand.wirq", int'(o_wake_irq),        int'(m_wirq));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
